// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, producing {HI, LO} = {remainder, quotient}.
// Holds busy_o high to freeze IF/ID/EX until the result is ready.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]     diff;

  function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
    return c ? -v : v;
  endfunction

  // The extra top bit keeps the trial-subtract borrow for divisors with the MSB set.
  assign diff = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    ready_d   = ready_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            // Signs are only recorded for DIV, so DIVU never triggers a fix-up negate.
            sign1_d   = signed_i & opdata1_i[WIDTH-1];
            sign2_d   = signed_i & opdata2_i[WIDTH-1];
            work_d    = {{WIDTH{1'b0}}, neg_if(signed_i & opdata1_i[WIDTH-1], opdata1_i), 1'b0};
            divisor_d = neg_if(signed_i & opdata2_i[WIDTH-1], opdata2_i);
          end
        end
      end
      DIVZERO: begin
        state_d  = DONE;
        result_d = '0;
        ready_d  = 1'b1;
      end
      RUN: begin
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_LAST) begin
          if (diff[WIDTH]) begin
            work_d = {work_q[2*WIDTH-1:0], 1'b0};
          end else begin
            work_d = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          result_d = {neg_if(sign1_q, work_q[2*WIDTH:WIDTH+1]),
                      neg_if(sign1_q ^ sign2_q, work_q[WIDTH-1:0])};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start_i || annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == RUN) || (state_q == DIVZERO) ||
               ((state_q == IDLE) && start_i && !annul_i);
    ready_o  = ready_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: directed divides with hand-computed {remainder, quotient}
// and expected ready cycle; a negedge monitor pops and compares on each rising ready_o.
module tb_hilo_div_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic          signed_i;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic ready_prev = 1'b0;

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .annul_i  (annul_i),
    .signed_i (signed_i),
    .opdata1_i(op1),
    .opdata2_i(op2),
    .result_o (result_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  // Monitor: every rising edge of ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ready: result 0x%h with no divide outstanding", result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", result_o, e.res);
        check("sb_ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    ready_prev = ready_o;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp_res, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.res = exp_res;
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    op1 = a;
    op2 = b;
    signed_i = s;
    start_i = 1'b1;
    #1 check("busy_on_start", 64'(busy_o), 64'd1);
  endtask

  task automatic finish_div(input string name, input logic [63:0] exp_res, input int lat);
    int busy_cnt;
    bit seen;
    busy_cnt = 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
      else if (busy_o) busy_cnt++;
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: ready_o not seen within 100 cycles, expected after %0d", name, lat);
    end else begin
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat + 1));
      check({name, "_busy_in_done"}, 64'(busy_o), 64'd0);
    end
    @(negedge clk);
    check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({name, "_hold_result"}, result_o, exp_res);
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_idle_ready"}, 64'(ready_o), 64'd0);
    check({name, "_idle_result"}, result_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_i = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b1);
    finish_div("u100_7", 64'h00000002_0000000E, 33);

    issue(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b1);
    finish_div("sm7_2", 64'hFFFFFFFF_FFFFFFFD, 33);

    issue(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b1);
    finish_div("s7_m2", 64'h00000001_FFFFFFFD, 33);

    issue(32'd123, 32'd0, 1'b0, 64'd0, 1, 1'b1);
    finish_div("udivzero", 64'd0, 1);

    issue(32'hFFFFFFFB, 32'd0, 1'b1, 64'd0, 1, 1'b1);
    finish_div("sdivzero", 64'd0, 1);

    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b1);
    finish_div("s_ovf", 64'h00000000_80000000, 33);

    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33, 1'b1);
    finish_div("u_big", 64'h80000000_00000000, 33);

    // Annul at cnt=10: no result may appear.
    issue(32'd1000, 32'd3, 1'b0, 64'd0, 33, 1'b0);
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    issue(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 33, 1'b1);
    finish_div("u50_5", 64'h00000000_0000000A, 33);

    // Reset at cnt=20 with start held high, then a clean restart.
    issue(32'd1234, 32'd5, 1'b0, 64'd0, 33, 1'b0);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_busy", 64'(busy_o), 64'(start_i));
    begin
      exp_t e;
      e.res = 64'h00000004_000000F6;
      e.cyc = cyc + 1 + 33;
      sb.push_back(e);
    end
    finish_div("restart", 64'h00000004_000000F6, 33);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
